xor_frame_signature: RTL and testbench
======================================

Name: xor_frame_signature

Overview:
- Downstream consumer of the 128-bit wide-XOR gate stage.
- Folds a stream of result words into a running XOR signature over a fixed-length frame, or a frame ended early by flush.
- Presents the frame signature, its reduction parity and its beat count through a valid/ready output, so cosim benches compare one word per frame instead of every beat.

Parameters:
- WIDTH, 128, data and signature width in bits.
- FRAME_LEN, 8, beats per full frame; legal range 1..255.
- CNT_W, 8, beat counter width; must satisfy 2**CNT_W > FRAME_LEN.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  upstream result word.
- flush  input  1  close the current frame early; single-cycle pulse.
- out_valid  output  1  signature available.
- out_ready  input  1  downstream accepts the signature.
- out_sig  output  WIDTH  XOR of all words accepted in the frame.
- out_parity  output  1  XOR-reduction of out_sig.
- out_count  output  CNT_W  number of beats folded into out_sig.

Behaviour:
- Reset (sync, rst=1 at an edge) sets every output and internal register as follows, regardless of state or handshake in flight:
  - state=ACCUM, acc=0, cnt=0.
  - out_valid=0, out_sig=0, out_parity=0, out_count=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - A partial frame in progress is discarded; a pending signature is dropped.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - Beat accepted when in_valid & in_ready: acc <= acc ^ in_data, cnt <= cnt+1.
  - Close frame when the accepted beat makes cnt+1 == FRAME_LEN, or when flush=1 and the post-update count is nonzero.
  - On close, the same edge loads out_sig <= final acc, out_count <= final cnt, out_parity <= ^final acc. It then clears acc and cnt and moves to HOLD.
  - Flush with a beat in the same cycle: the beat is included, then the frame closes.
  - Flush with cnt==0 and no beat: ignored, no empty frame is emitted.
- HOLD:
  - out_valid=1 and in_ready=0; in_data and flush are ignored.
  - out_sig, out_parity and out_count are held stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to ACCUM next cycle with out_valid=0. There is no bypass, so in_ready returns one cycle after the output handshake.
- Latency: signature visible the cycle after the closing beat or flush edge.
- Throughput: FRAME_LEN beats per FRAME_LEN+1 cycles minimum, with out_ready tied high.
- Arithmetic:
  - XOR is bitwise over the full WIDTH with no sign extension; in_data is treated as unsigned bits.
  - cnt never exceeds FRAME_LEN, so no wrap.
- X handling: X/Z on in_data propagates into acc and out_sig bitwise, matching the gate semantics upstream. Control inputs are assumed 2-state after reset.
- FRAME_LEN=1: every accepted beat closes a frame immediately. flush is then irrelevant.
- out_parity is combinationally independent of the inputs; it is registered with out_sig.

Test Plan:
1. Reset, then 8 beats with in_data = 128'h1 << k for k=0..7, out_ready=1. Required: out_valid one cycle after beat 8, out_sig=128'hFF, out_parity=0, out_count=8; in_ready=0 for exactly one cycle.
2. Three beats 128'hA5 repeated, plus flush on the third beat. Required: out_sig=128'hA5, out_count=3, out_parity=0.
3. Flush with no beats since reset, and flush pulsed in HOLD. Required: no out_valid from the first; no effect on out_sig/out_count from the second.
4. Full frame closed, out_ready=0 for 5 cycles while in_valid=1 with varying in_data. Required: out_sig/out_count stable, in_ready=0, no beats lost; first beat accepted the cycle after out_ready rises.
5. rst asserted after 4 beats, and separately while HOLD with out_ready=0. Required: next cycle out_valid=0, out_sig=0, out_count=0; the following 8-beat frame of all-ones words gives out_sig=0, out_count=8.
6. FRAME_LEN=1 build, beats 128'h3, 128'h7 back-to-back with out_ready=1. Required: two frames, out_sig=128'h3 (parity 0) then 128'h7 (parity 1), each out_count=1.

Source files
------------

// File: rtl/xor_frame_signature.sv
// Folds a stream of WIDTH-bit result words into a per-frame XOR signature and
// presents it, with its parity and beat count, through a valid/ready output.
module xor_frame_signature #(
    parameter int WIDTH     = 128,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sig,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             beat;
    logic             close;

    // Post-beat accumulator and count; the closing edge captures these so a
    // beat arriving together with flush is folded into the frame it closes.
    always_comb begin
        beat     = in_valid && in_ready && (state == ACCUM);
        acc_next = acc;
        cnt_next = cnt;
        if (beat) begin
            acc_next = acc ^ in_data;
            cnt_next = cnt + CNT_W'(1);
        end
        close = (state == ACCUM) &&
                ((beat && (cnt_next == CNT_W'(FRAME_LEN))) ||
                 (flush && (cnt_next != '0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_sig    <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (close) begin
                        out_sig    <= acc_next;
                        out_count  <= cnt_next;
                        out_parity <= ^acc_next;
                        acc        <= '0;
                        cnt        <= '0;
                        out_valid  <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= HOLD;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_frame_signature.sv
// Scoreboard bench for xor_frame_signature: an 8-beat instance for the main
// scenarios and a FRAME_LEN=1 instance for single-beat frames.
module tb_xor_frame_signature;

    typedef struct {
        logic [127:0] sig;
        logic [7:0]   cnt;
        logic         par;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_sig;
    logic         out_parity;
    logic [7:0]   out_count;

    logic         v1 = 1'b0;
    logic [127:0] d1 = '0;
    logic         f1 = 1'b0;
    logic         or1 = 1'b1;
    logic         ir1;
    logic         ov1;
    logic [127:0] os1;
    logic         op1;
    logic [7:0]   oc1;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    xor_frame_signature #(.WIDTH(128), .FRAME_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_sig(out_sig), .out_parity(out_parity),
        .out_count(out_count)
    );

    xor_frame_signature #(.WIDTH(128), .FRAME_LEN(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1),
        .in_data(d1), .flush(f1), .out_valid(ov1),
        .out_ready(or1), .out_sig(os1), .out_parity(op1),
        .out_count(oc1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_sig !== 128'h0) begin n_fail++; $display("FAIL reset_out_sig got %h want 0", out_sig); end
        n_checks++;
        if (out_count !== 8'd0 || out_parity !== 1'b0) begin
            n_fail++; $display("FAIL reset_count_par got %0d/%b want 0/0", out_count, out_parity);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_full_frame();
        logic [127:0] one = 128'h1;
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = one << k;
            if (k == 7) sbq.push_back('{sig: 128'hFF, cnt: 8'd8, par: 1'b0});
            cyc();
            if (k < 7) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid beat %0d got %b want 0", k, out_valid); end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_close valid/ready got %b/%b want 1/0", out_valid, in_ready);
        end
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL full_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({out_sig, out_count, out_parity} !== {e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL full_sig got %h/%0d/%b want %h/%0d/%b", out_sig, out_count, out_parity, e.sig, e.cnt, e.par);
            end
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_release valid/ready got %b/%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush_early();
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 128'hA5;
            flush    = (k == 2);
            if (k == 2) sbq.push_back('{sig: 128'hA5, cnt: 8'd3, par: 1'b0});
            cyc();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b want 1", out_valid); end
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL flush_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({out_sig, out_count, out_parity} !== {e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL flush_sig got %h/%0d/%b want %h/%0d/%b", out_sig, out_count, out_parity, e.sig, e.cnt, e.par);
            end
        end
        cyc();
    endtask

    task automatic test_flush_idle();
        exp_t e;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_flush_valid got %b want 0", out_valid); end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 128'(k + 1);
            if (k == 7) sbq.push_back('{sig: 128'h8, cnt: 8'd8, par: 1'b1});
            cyc();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        cyc();
        flush = 1'b0;
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL hold_flush_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({out_valid, out_sig, out_count, out_parity} !== {1'b1, e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL hold_flush_sig got %b/%h/%0d/%b want 1/%h/%0d/%b", out_valid, out_sig, out_count, out_parity, e.sig, e.cnt, e.par);
            end
        end
        out_ready = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_flush_phantom got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [127:0] one = 128'h100;
        logic [127:0] x;
        exp_t e;
        int acc_beats;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = one << k;
            if (k == 7) sbq.push_back('{sig: 128'hFF00, cnt: 8'd8, par: 1'b0});
            cyc();
        end
        for (int i = 0; i < 5; i++) begin
            in_data = {96'hDEAD, 32'(i)};
            cyc();
            n_checks++;
            if ({in_ready, out_valid, out_sig, out_count} !== {1'b0, 1'b1, 128'hFF00, 8'd8}) begin
                n_fail++; $display("FAIL bp_stall cyc %0d got %b/%b/%h/%0d want 0/1/ff00/8", i, in_ready, out_valid, out_sig, out_count);
            end
        end
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL bp_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({out_sig, out_count, out_parity} !== {e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL bp_sig got %h/%0d/%b want %h/%0d/%b", out_sig, out_count, out_parity, e.sig, e.cnt, e.par);
            end
        end
        out_ready = 1'b1;
        in_data   = 128'hBAD;
        cyc();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release ready/valid got %b/%b want 1/0", in_ready, out_valid);
        end
        x = '0;
        acc_beats = 0;
        for (int k = 0; k < 8; k++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            x = x ^ in_data;
            acc_beats++;
            if (k == 7) sbq.push_back('{sig: x, cnt: 8'(acc_beats), par: ^x});
            cyc();
        end
        in_valid = 1'b0;
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL bp_next_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({out_valid, out_sig, out_count, out_parity} !== {1'b1, e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL bp_next_sig got %b/%h/%0d/%b want 1/%h/%0d/%b", out_valid, out_sig, out_count, out_parity, e.sig, e.cnt, e.par);
            end
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 128'(32'hC0DE0000 + k);
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_sig, out_count} !== {1'b0, 128'h0, 8'd0}) begin
            n_fail++; $display("FAIL rst_partial got %b/%h/%0d want 0/0/0", out_valid, out_sig, out_count);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = '1;
            if (k == 7) sbq.push_back('{sig: 128'h0, cnt: 8'd8, par: 1'b0});
            cyc();
        end
        in_valid = 1'b0;
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL rst_frame_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({out_valid, out_sig, out_count, out_parity} !== {1'b1, e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL rst_frame_sig got %b/%h/%0d/%b want 1/%h/%0d/%b", out_valid, out_sig, out_count, out_parity, e.sig, e.cnt, e.par);
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_sig, out_count, in_ready} !== {1'b0, 128'h0, 8'd0, 1'b1}) begin
            n_fail++; $display("FAIL rst_hold got %b/%h/%0d/%b want 0/0/0/1", out_valid, out_sig, out_count, in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_len1();
        exp_t e;
        or1 = 1'b1;
        v1  = 1'b1;
        d1  = 128'h3;
        sbq.push_back('{sig: 128'h3, cnt: 8'd1, par: 1'b0});
        cyc();
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL len1_a_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({ov1, os1, oc1, op1} !== {1'b1, e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL len1_a got %b/%h/%0d/%b want 1/%h/%0d/%b", ov1, os1, oc1, op1, e.sig, e.cnt, e.par);
            end
        end
        d1 = 128'h7;
        sbq.push_back('{sig: 128'h7, cnt: 8'd1, par: 1'b1});
        cyc();
        n_checks++;
        if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
            n_fail++; $display("FAIL len1_gap valid/ready got %b/%b want 0/1", ov1, ir1);
        end
        cyc();
        v1 = 1'b0;
        n_checks++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL len1_b_sb empty queue"); end
        else begin
            e = sbq.pop_front();
            if ({ov1, os1, oc1, op1} !== {1'b1, e.sig, e.cnt, e.par}) begin
                n_fail++; $display("FAIL len1_b got %b/%h/%0d/%b want 1/%h/%0d/%b", ov1, os1, oc1, op1, e.sig, e.cnt, e.par);
            end
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush_early();
        test_flush_idle();
        test_backpressure();
        test_reset_mid();
        test_len1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
